// File: rtl/sc_level_transition_seq_pkg.sv
// Shared definitions for the level-transition sequencer and the row-register array:
// sequencer states, array geometry and the per-row level pattern rotation.
package sc_level_transition_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WIPE = 2'd1,
      ST_FILL = 2'd2,
      ST_DONE = 2'd3
   } seqState_t;

   localparam int SC_NUM_ROWS      = 8;
   localparam int SC_DATAWIDTH     = 8;
   localparam int SC_MAX_DATAWIDTH = 32;

   // Rotate the low 'width' bits of base left by (amount mod width); width must be 1..32.
   function automatic logic [31:0] rotlPattern(input logic [31:0] base,
                                               input int unsigned width,
                                               input int unsigned amount);
      logic [63:0]  shifted;
      logic [31:0]  mask;
      int unsigned  sh;
      mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      sh      = amount % width;
      shifted = {32'd0, base & mask} << sh;
      return (shifted[31:0] | 32'(shifted >> width)) & mask;
   endfunction

endpackage

// File: rtl/sc_step_timer.sv
// Modulo-STEP_TICKS cycle counter; tick is high on the last count of each step period.
module sc_step_timer #(
   parameter int STEP_TICKS = 12_500_000
) (
   input  logic SC_StepTimer_CLOCK_50,
   input  logic SC_StepTimer_RESET_InLow,
   input  logic SC_StepTimer_restart_InHigh,
   output logic SC_StepTimer_tick_Out
);

   localparam int CNT_W = $clog2(STEP_TICKS);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(STEP_TICKS - 1);

   logic [CNT_W-1:0] stepCount_p0;

   always_ff @(posedge SC_StepTimer_CLOCK_50 or negedge SC_StepTimer_RESET_InLow) begin
      if (!SC_StepTimer_RESET_InLow) begin
         stepCount_p0 <= '0;
      end else if (SC_StepTimer_restart_InHigh || (stepCount_p0 == LAST_COUNT)) begin
         stepCount_p0 <= '0;
      end else begin
         stepCount_p0 <= stepCount_p0 + 1'b1;
      end
   end

   assign SC_StepTimer_tick_Out = (stepCount_p0 == LAST_COUNT);

endmodule

// File: rtl/sc_level_transition_seq.sv
// Level-up sequencer: wipes every background row to zero, then fills each row with the
// new level's rotated pattern, one row strobe per step period, holding busy meanwhile.
module sc_level_transition_seq
   import sc_level_transition_seq_pkg::*;
#(
   parameter int NUM_ROWS   = SC_NUM_ROWS,
   parameter int DATAWIDTH  = SC_DATAWIDTH,
   parameter int STEP_TICKS = 12_500_000,
   parameter logic [DATAWIDTH-1:0] DATA_FIXED_NIVEL_1 = DATAWIDTH'(8'b00110011),
   parameter logic [DATAWIDTH-1:0] DATA_FIXED_NIVEL_2 = DATAWIDTH'(8'b01100110),
   parameter logic [DATAWIDTH-1:0] DATA_FIXED_NIVEL_3 = DATAWIDTH'(8'b11001100),
   parameter logic [DATAWIDTH-1:0] DATA_FIXED_NIVEL_4 = DATAWIDTH'(8'b10011001)
) (
   input  logic                 SC_LevelTransitionSeq_CLOCK_50,
   input  logic                 SC_LevelTransitionSeq_RESET_InLow,
   input  logic                 SC_LevelTransitionSeq_start_InLow,
   input  logic [1:0]           SC_LevelTransitionSeq_level_InBUS,
   output logic [NUM_ROWS-1:0]  SC_LevelTransitionSeq_transition_OutBUS,
   output logic [DATAWIDTH-1:0] SC_LevelTransitionSeq_transitionDATA_OutBUS,
   output logic                 SC_LevelTransitionSeq_busy_Out,
   output logic                 SC_LevelTransitionSeq_done_Out
);

   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

   seqState_t         stateReg, stateNext;
   logic [ROW_W-1:0]  rowIdx_p0, rowNext;
   logic [1:0]        levelReg_p0, levelNext;
   logic              startPrev_p0;

   logic [NUM_ROWS-1:0]  transNext;
   logic [DATAWIDTH-1:0] dataNext;
   logic [DATAWIDTH-1:0] baseNext;
   logic                 busyNext;
   logic                 doneNext;
   logic                 strobeNext;
   logic                 fillNext;
   logic                 startFall;
   logic                 timerRestart;
   logic                 stepTick;

   sc_step_timer #(
      .STEP_TICKS (STEP_TICKS)
   ) u_stepTimer (
      .SC_StepTimer_CLOCK_50       (SC_LevelTransitionSeq_CLOCK_50),
      .SC_StepTimer_RESET_InLow    (SC_LevelTransitionSeq_RESET_InLow),
      .SC_StepTimer_restart_InHigh (timerRestart),
      .SC_StepTimer_tick_Out       (stepTick)
   );

   assign startFall    = startPrev_p0 && !SC_LevelTransitionSeq_start_InLow;
   // Holding the timer cleared outside the passes puts count 0 on every strobe cycle.
   assign timerRestart = (stateReg == ST_IDLE) || (stateReg == ST_DONE);

   always_comb begin
      stateNext  = stateReg;
      rowNext    = rowIdx_p0;
      levelNext  = levelReg_p0;
      busyNext   = 1'b0;
      doneNext   = 1'b0;
      strobeNext = 1'b0;
      fillNext   = 1'b0;

      unique case (stateReg)
         ST_IDLE: begin
            if (startFall) begin
               levelNext  = SC_LevelTransitionSeq_level_InBUS;
               rowNext    = '0;
               stateNext  = ST_WIPE;
               busyNext   = 1'b1;
               strobeNext = 1'b1;
            end
         end
         ST_WIPE: begin
            busyNext = 1'b1;
            if (stepTick) begin
               strobeNext = 1'b1;
               if (rowIdx_p0 == LAST_ROW) begin
                  stateNext = ST_FILL;
                  rowNext   = '0;
                  fillNext  = 1'b1;
               end else begin
                  rowNext = rowIdx_p0 + 1'b1;
               end
            end
         end
         ST_FILL: begin
            busyNext = 1'b1;
            if (stepTick) begin
               if (rowIdx_p0 == LAST_ROW) begin
                  stateNext = ST_DONE;
                  doneNext  = 1'b1;
               end else begin
                  rowNext    = rowIdx_p0 + 1'b1;
                  strobeNext = 1'b1;
                  fillNext   = 1'b1;
               end
            end
         end
         ST_DONE: begin
            stateNext = ST_IDLE;
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      unique case (levelNext)
         2'd0:    baseNext = DATA_FIXED_NIVEL_1;
         2'd1:    baseNext = DATA_FIXED_NIVEL_2;
         2'd2:    baseNext = DATA_FIXED_NIVEL_3;
         default: baseNext = DATA_FIXED_NIVEL_4;
      endcase
   end

   always_comb begin
      transNext = '0;
      dataNext  = '0;
      if (strobeNext) begin
         transNext = NUM_ROWS'(1) << rowNext;
         if (fillNext) begin
            dataNext = DATAWIDTH'(rotlPattern(32'(baseNext), unsigned'(DATAWIDTH), 32'(rowNext)));
         end
      end
   end

   // Registered outputs and control state
   always_ff @(posedge SC_LevelTransitionSeq_CLOCK_50 or negedge SC_LevelTransitionSeq_RESET_InLow) begin
      if (!SC_LevelTransitionSeq_RESET_InLow) begin
         stateReg     <= ST_IDLE;
         rowIdx_p0    <= '0;
         levelReg_p0  <= '0;
         startPrev_p0 <= 1'b0;
         SC_LevelTransitionSeq_transition_OutBUS     <= '0;
         SC_LevelTransitionSeq_transitionDATA_OutBUS <= '0;
         SC_LevelTransitionSeq_busy_Out              <= 1'b0;
         SC_LevelTransitionSeq_done_Out              <= 1'b0;
      end else begin
         stateReg     <= stateNext;
         rowIdx_p0    <= rowNext;
         levelReg_p0  <= levelNext;
         startPrev_p0 <= SC_LevelTransitionSeq_start_InLow;
         SC_LevelTransitionSeq_transition_OutBUS     <= transNext;
         SC_LevelTransitionSeq_transitionDATA_OutBUS <= dataNext;
         SC_LevelTransitionSeq_busy_Out              <= busyNext;
         SC_LevelTransitionSeq_done_Out              <= doneNext;
      end
   end

endmodule

// File: doc/sc_level_transition_seq.md
# sc_level_transition_seq

Level-transition sequencer for the background row registers. On a level-up request it drives the per-row transition strobe and transition data consumed by each row register in two passes, one row per step period. The first pass wipes every row to 0x00. The second pass fills each row with the new level's pattern. While it runs it asserts busy so game logic freezes load/shift. It sits directly upstream of the row-register array and downstream of the game-control state machine.

## Interface
Parameters:
- NUM_ROWS, 8, number of background rows driven; one strobe bit per row.
- DATAWIDTH, 8, row width in bits.
- STEP_TICKS, 12_500_000, clock cycles between consecutive row strobes (0.25 s at 50 MHz); must be ≥ 2.
- DATA_FIXED_NIVEL_1 … DATA_FIXED_NIVEL_4, 8'b00110011 / 8'b01100110 / 8'b11001100 / 8'b10011001, base row pattern per level.

Ports:
- SC_LevelTransitionSeq_CLOCK_50  in  1  system clock, 50 MHz.
- SC_LevelTransitionSeq_RESET_InLow  in  1  reset; one clock; reset is asynchronous and active-low.
- SC_LevelTransitionSeq_start_InLow  in  1  level-up request, active low; accepted on a high→low transition.
- SC_LevelTransitionSeq_level_InBUS  in  2  target level; 0..3 selects NIVEL_1..4; sampled on accept.
- SC_LevelTransitionSeq_transition_OutBUS  out  NUM_ROWS  one-hot row strobe; bit r feeds row r.
- SC_LevelTransitionSeq_transitionDATA_OutBUS  out  DATAWIDTH  data for the strobed row.
- SC_LevelTransitionSeq_busy_Out  out  1  high from accept through done.
- SC_LevelTransitionSeq_done_Out  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, WIPE, FILL, DONE.
- IDLE: all outputs 0. The start input is registered once for edge detection. A falling edge latches the level and row index = 0, then moves to WIPE.
- WIPE: in the first cycle of each step, assert transition bit [row] and drive data = 0x00, for exactly one cycle. Next, count STEP_TICKS cycles and increment row. After the step of row NUM_ROWS-1 completes, enter FILL with row = 0.
- FILL: same strobing, with data = pattern(level, row) = base pattern rotated left by (row mod DATAWIDTH). For example, NIVEL_1 row 1 = 8'b01100110.
- After the FILL step of row NUM_ROWS-1 completes, enter DONE. DONE lasts one cycle: done_Out = 1, busy_Out = 1. Then return to IDLE.
- transition_OutBUS is 0 or one-hot, never multi-hot. transitionDATA_OutBUS is 0x00 whenever no strobe is active.
- Start edges while not in IDLE are ignored, including in DONE. level_InBUS changes after accept have no effect.
- Reset asserted at any point, including mid-pass: state returns to IDLE asynchronously and all outputs are 0 immediately. Rows already written keep their values, because that is the row registers' responsibility.
- Step counter width is clog2(STEP_TICKS). It wraps from STEP_TICKS-1 to 0 at each row advance. Row index width is clog2(NUM_ROWS).

## Timing
- All outputs are registered.
- Reset value: transition 0, data 0x00, busy 0, done 0.
- The start falling edge is seen at cycle 0 (the registered-edge cycle). busy rises at cycle 1, together with the row-0 WIPE strobe.
- Strobe n (n = 0 … 2·NUM_ROWS-1) occurs at cycle 1 + n·STEP_TICKS. Strobes n < NUM_ROWS are WIPE of row n; the rest are FILL of row n-NUM_ROWS.
- done pulses at cycle 1 + 2·NUM_ROWS·STEP_TICKS. busy falls in the following cycle.
- The row register captures the strobe on the next clock edge, so each row updates one cycle after its strobe.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE/WIPE/FILL/DONE);
  - the rotate-left pattern function;
  - the row-count and width constants used by the row-register array.
- One sub-module: sc_step_timer. It is a STEP_TICKS modulo counter with a synchronous restart input and a one-cycle tick output. The FSM uses it for row pacing.

## Test plan
(Bench parameters: STEP_TICKS = 4, NUM_ROWS = 8.)
- Reset check: hold reset low, then release -> all outputs 0, busy 0. No strobes for 50 cycles with start held high.
- Full sequence, level 0: drive start 1→0 with level 0 -> 16 one-hot strobes at cycles 1, 5, …, 61.
  - First 8 strobes carry data 0x00 on rows 0..7.
  - Next 8 carry 0x33, 0x66, 0xCC, 0x99, 0x33, … on rows 0..7.
  - done at cycle 65; busy 1 over cycles 1–65.
- Level 3 pattern: start with level 3 -> FILL row 0 = 0x99, row 1 = 0x33, row 2 = 0x66.
- Ignored start: pulse start again at cycle 20 and change level to 1 mid-sequence -> sequence timing and level-0 patterns are unchanged, and exactly one done pulse occurs.
- Reset mid-operation: assert reset at cycle 30, release at 35 -> outputs 0 immediately and state IDLE. A new start afterwards restarts from WIPE row 0.
- Held start: keep start low continuously after the sequence ends -> no second sequence until start returns high and falls again.
